// File: rtl/backend_types_pkg.sv
// Shared backend sizing for the rename/commit loop.
// Physical register IDs and free-list pointer types live here.
package backend_types;

    localparam int NUM_PHYS_REGS      = 64;
    localparam int NUM_ARCH_REGISTERS = 32;
    localparam int PHYS_REG_WIDTH     = $clog2(NUM_PHYS_REGS);
    localparam int FL_DEPTH           = NUM_PHYS_REGS - NUM_ARCH_REGISTERS;
    localparam int FL_IDX_WIDTH       = $clog2(FL_DEPTH);
    localparam int FL_PTR_WIDTH       = FL_IDX_WIDTH + 1;

    typedef logic [FL_PTR_WIDTH-1:0]   fl_ptr_t;
    typedef logic [PHYS_REG_WIDTH-1:0] prd_t;

endpackage

// File: rtl/free_list.sv
// Circular free list of physical register IDs with a speculative and a
// retirement head; flush rewinds the speculative head to the retirement head.
module free_list
    import backend_types::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      deq_en_i,
    output logic [PHYS_REG_WIDTH-1:0] deq_prd_o,
    output logic                      empty_o,
    output logic [FL_PTR_WIDTH-1:0]   free_count_o,
    input  logic                      enq_en_i,
    input  logic [PHYS_REG_WIDTH-1:0] enq_prd_i,
    input  logic                      retire_en_i,
    input  logic                      flush_i
);

    localparam fl_ptr_t FL_FULL = fl_ptr_t'(FL_DEPTH);
    localparam fl_ptr_t PTR_ONE = fl_ptr_t'(1);

    fl_ptr_t specHead_q, specHead_d;
    fl_ptr_t archHead_q, archHead_d;
    fl_ptr_t tail_q, tail_d;
    prd_t    mem_q [FL_DEPTH];

    fl_ptr_t freeCount;
    fl_ptr_t occupancy;
    logic    emptyInt;
    logic    full;
    logic    deqFire;
    logic    enqFire;

    assign freeCount = tail_q - specHead_q;
    assign occupancy = tail_q - archHead_q;
    assign emptyInt  = (freeCount == '0);
    // A retire in the same cycle frees the slot that the commit's old mapping refills.
    assign full      = (occupancy == FL_FULL) && !retire_en_i;
    assign deqFire   = deq_en_i && !emptyInt && !flush_i;
    assign enqFire   = enq_en_i && !full;

    assign deq_prd_o    = mem_q[specHead_q[FL_IDX_WIDTH-1:0]];
    assign empty_o      = emptyInt;
    assign free_count_o = freeCount;

    always_comb begin
        archHead_d = archHead_q;
        specHead_d = specHead_q;
        tail_d     = tail_q;
        if (retire_en_i) begin
            archHead_d = archHead_q + PTR_ONE;
        end
        if (flush_i) begin
            specHead_d = archHead_d;
        end else if (deqFire) begin
            specHead_d = specHead_q + PTR_ONE;
        end
        if (enqFire) begin
            tail_d = tail_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            specHead_q <= '0;
            archHead_q <= '0;
            tail_q     <= FL_FULL;
            for (int i = 0; i < FL_DEPTH; i++) begin
                mem_q[i] <= prd_t'(NUM_ARCH_REGISTERS + i);
            end
        end else begin
            specHead_q <= specHead_d;
            archHead_q <= archHead_d;
            tail_q     <= tail_d;
            if (enqFire) begin
                mem_q[tail_q[FL_IDX_WIDTH-1:0]] <= enq_prd_i;
            end
        end
    end

    // Protocol and pointer-order checks; the datapath already ignores the offending request.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(deq_en_i && emptyInt && !flush_i))
                else $warning("free_list: deq_en while empty ignored");
            assert (!(enq_en_i && full))
                else $warning("free_list: enqueue beyond depth dropped");
            assert (((specHead_q - archHead_q) <= occupancy) && (occupancy <= FL_FULL))
                else $warning("free_list: pointer order arch<=spec<=tail broken");
        end
    end

endmodule

// File: doc/free_list.md
# free_list

Circular FIFO of free physical register IDs for the rename/commit loop of the out-of-order backend. Rename dequeues a fresh destination PRD each cycle. Commit enqueues the PRD displaced in the retirement register file, i.e. its old mapping, once that mapping is overwritten. A second, retirement-side head pointer advances on every committing allocator. On flush, the speculative head snaps back to it, so every PRD allocated by squashed instructions is reclaimed in one cycle.

## Interface
- NUM_PHYS_REGS, 64, total physical registers.
- NUM_ARCH_REGISTERS, 32, architectural registers; PRDs 0..31 are mapped at reset.
- PHYS_REG_WIDTH, 6, clog2(NUM_PHYS_REGS).
- FL_DEPTH, NUM_PHYS_REGS-NUM_ARCH_REGISTERS (32), queue entries.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- deq_en  in  1  rename consumes deq_prd this cycle; legal only when !empty.
- deq_prd  out  PHYS_REG_WIDTH  PRD at speculative head.
- empty  out  1  no free PRD available to rename.
- free_count  out  clog2(FL_DEPTH)+1  speculative free entries.
- enq_en  in  1  commit frees enq_prd (RRF write with changed mapping).
- enq_prd  in  PHYS_REG_WIDTH  freed PRD (RRF old mapping).
- retire_en  in  1  committing instruction had allocated a PRD (rd != x0).
- flush  in  1  squash all uncommitted instructions.

## Operation
- Storage: FL_DEPTH x PHYS_REG_WIDTH array; pointers spec_head, arch_head, tail, each clog2(FL_DEPTH)+1 bits (MSB = wrap bit).
- Reset: entry i = NUM_ARCH_REGISTERS+i (32..63); spec_head=arch_head=0; tail=FL_DEPTH (wrap bit set). Outputs after reset: deq_prd=32, empty=0, free_count=32.
- Dequeue: deq_en && !empty → spec_head+1. deq_en while empty is a protocol violation: assert, ignore.
- Enqueue: enq_en → mem[tail]=enq_prd, tail+1. Enqueue while tail-arch_head==FL_DEPTH is a violation: assert, drop.
- Retire: retire_en → arch_head+1. Commit retires in rename order, so mem[arch_head] is exactly the PRD that instruction received.
- Flush: spec_head ← arch_head (after this cycle's retire increment). tail is untouched; committed frees are never lost.
- free_count = tail - spec_head (modular, full pointer width); empty = (free_count==0).
- Invariant: arch_head ≤ spec_head ≤ tail in modular order. Violations flagged by assertions only.

## Timing
- deq_prd and empty are combinational from registered state; no input-to-output paths.
- All state updates occur on posedge clk.
- Enqueue has no bypass: a PRD enqueued in cycle N is first visible at deq_prd in N+1. empty in cycle N ignores that cycle's enq_en.
- Simultaneous deq+enq: both apply; free_count unchanged.
- flush priority: deq_en ignored in a flush cycle. enq_en and retire_en in the same cycle are honoured, and spec_head takes the post-retire arch_head.
- Pointer wrap: index = low bits; wrap bit toggles at FL_DEPTH; full/empty distinguished by wrap bit.
- rst mid-operation overrides everything and restores the reset image, including memory contents.

## Structure
- backend_types package: NUM_PHYS_REGS, NUM_ARCH_REGISTERS, PHYS_REG_WIDTH, FL_DEPTH, fl_ptr_t typedef (clog2(FL_DEPTH)+1 bits).
- No sub-module; three pointers and the array are inline.
- Connects to the RRF: enq_prd = RRF free_prd; enq_en = RRF wen && valid.

## Test plan
- Reset then 32 consecutive deq_en: deq_prd 32,33,…,63; empty=1 after the 32nd; free_count 0.
- From empty, enq_en with enq_prd=5: empty stays 1 that cycle; next cycle deq_prd=5, free_count=1.
- Dequeue 3 (32,33,34), retire_en once, flush: next cycle deq_prd=33, free_count=31.
- Same cycle flush+retire_en+enq_en(prd=7) after dequeuing 32,33: spec_head=arch_head=1 → deq_prd=33. A later dequeue run reaches 7 after entry 63.
- Steady state: 100 cycles of deq+enq+retire per cycle with random PRDs. Pointers wrap correctly; free_count constant; dequeued order equals enqueue order.
- Assert fires on deq_en while empty and on enqueue beyond FL_DEPTH; state is unchanged in both cases.
